// File: rtl/reset_sequencer.sv
// Boot reset fan-out: qualifies PLL lock, then releases N_STAGES active-low resets in order.
// Re-asserts all stages together on lock loss or a software reset request.
module reset_sequencer #(
    parameter int unsigned N_STAGES   = 4,
    parameter int unsigned STAGE_DLY  = 16,
    parameter int unsigned LOCK_FILT  = 8,
    parameter int unsigned SW_RST_MIN = 32
) (
    input  logic                clk,
    input  logic                reset_n_i,
    input  logic                pll_lock_i,
    input  logic                sw_reset_i,
    output logic [N_STAGES-1:0] rst_n_o,
    output logic                ready_o,
    output logic [7:0]          lock_loss_cnt_o
);

    localparam int unsigned FW  = $clog2(LOCK_FILT + 1);
    localparam int unsigned DW  = $clog2(STAGE_DLY + 1);
    localparam int unsigned HW  = $clog2(SW_RST_MIN + 1);
    localparam int unsigned SGW = $clog2(N_STAGES + 1);

    localparam logic [FW-1:0]  FILT_LAST = FW'(LOCK_FILT - 1);
    localparam logic [DW-1:0]  DLY_LAST  = DW'(STAGE_DLY - 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(SW_RST_MIN - 1);
    localparam logic [SGW-1:0] STG_DONE  = SGW'(N_STAGES);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RELEASE   = 2'd1,
        RUN       = 2'd2,
        SW_HOLD   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                lock_meta_q, lock_s_q;
    logic [FW-1:0]       filt_q, filt_d;
    logic [DW-1:0]       dly_q, dly_d;
    logic [SGW-1:0]      stg_q, stg_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [N_STAGES-1:0] rst_q, rst_d;
    logic                ready_q, ready_d;
    logic [7:0]          cnt_q, cnt_d;

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock_i;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= WAIT_LOCK;
            filt_q  <= '0;
            dly_q   <= '0;
            stg_q   <= '0;
            hold_q  <= '0;
            rst_q   <= '0;
            ready_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
            dly_q   <= dly_d;
            stg_q   <= stg_d;
            hold_q  <= hold_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        filt_d  = '0;
        dly_d   = dly_q;
        stg_d   = stg_q;
        hold_d  = hold_q;
        rst_d   = rst_q;
        ready_d = ready_q;
        cnt_d   = cnt_q;

        case (state_q)
            WAIT_LOCK: begin
                rst_d   = '0;
                ready_d = 1'b0;
                if (lock_s_q) begin
                    if (filt_q == FILT_LAST) begin
                        state_d = RELEASE;
                        dly_d   = '0;
                        stg_d   = '0;
                    end else begin
                        filt_d = filt_q + 1'b1;
                    end
                end
            end

            RELEASE, RUN: begin
                if (!lock_s_q && cnt_q != 8'hFF)
                    cnt_d = cnt_q + 8'd1;
                // Software request outranks lock loss; the loss is still counted above.
                if (sw_reset_i) begin
                    state_d = SW_HOLD;
                    hold_d  = '0;
                    rst_d   = '0;
                    ready_d = 1'b0;
                end else if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                    rst_d   = '0;
                    ready_d = 1'b0;
                end else if (state_q == RELEASE) begin
                    if (dly_q == '0) begin
                        if (stg_q == STG_DONE) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                        end else begin
                            // Shifting a one in from bit 0 keeps release strictly ordered.
                            rst_d = (rst_q << 1) | N_STAGES'(1);
                            stg_d = stg_q + 1'b1;
                            dly_d = DLY_LAST;
                        end
                    end else begin
                        dly_d = dly_q - 1'b1;
                    end
                end else begin
                    rst_d   = '1;
                    ready_d = 1'b1;
                end
            end

            SW_HOLD: begin
                rst_d   = '0;
                ready_d = 1'b0;
                if (sw_reset_i) begin
                    hold_d = '0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = WAIT_LOCK;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end

            default: begin
                state_d = WAIT_LOCK;
                rst_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    assign rst_n_o         = rst_q;
    assign ready_o         = ready_q;
    assign lock_loss_cnt_o = cnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus queues expected output changes with their
// cycle numbers; a monitor pops one entry for every observed change of the outputs.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset_n_i;
    logic       pll_lock_i;
    logic       sw_reset_i;
    logic [3:0] rst_n_o;
    logic       ready_o;
    logic [7:0] lock_loss_cnt_o;

    int cyc = 0;
    int checks = 0;
    int fails = 0;

    typedef struct {
        int         cyc;
        logic [3:0] rst;
        logic       rdy;
        logic [7:0] cnt;
    } ev_t;

    ev_t exp_q[$];

    reset_sequencer #(
        .N_STAGES  (4),
        .STAGE_DLY (16),
        .LOCK_FILT (8),
        .SW_RST_MIN(32)
    ) dut (
        .clk            (clk),
        .reset_n_i      (reset_n_i),
        .pll_lock_i     (pll_lock_i),
        .sw_reset_i     (sw_reset_i),
        .rst_n_o        (rst_n_o),
        .ready_o        (ready_o),
        .lock_loss_cnt_o(lock_loss_cnt_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [3:0] r, input logic rd, input logic [7:0] n);
        ev_t e;
        e.cyc = c;
        e.rst = r;
        e.rdy = rd;
        e.cnt = n;
        exp_q.push_back(e);
    endtask

    // Full release: bit 0 at b0, one more bit every 16 cycles, ready 16 after the last bit.
    task automatic push_seq(input int b0, input logic [7:0] n);
        push(b0,      4'b0001, 1'b0, n);
        push(b0 + 16, 4'b0011, 1'b0, n);
        push(b0 + 32, 4'b0111, 1'b0, n);
        push(b0 + 48, 4'b1111, 1'b0, n);
        push(b0 + 64, 4'b1111, 1'b1, n);
    endtask

    task automatic goto_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every change of the observable outputs must match the next queued expectation.
    initial begin
        logic [12:0] prev;
        logic [12:0] cur;
        bit          first;
        ev_t         e;
        first = 1'b1;
        prev  = '0;
        forever begin
            @(negedge clk);
            cur = {rst_n_o, ready_o, lock_loss_cnt_o};
            if (first || cur !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_change cyc=%0d rst_n=%b ready=%b cnt=%0d",
                             cyc, rst_n_o, ready_o, lock_loss_cnt_o);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || rst_n_o !== e.rst || ready_o !== e.rdy ||
                        lock_loss_cnt_o !== e.cnt) begin
                        fails++;
                        $display("FAIL output_event got cyc=%0d rst_n=%b ready=%b cnt=%0d, expected cyc=%0d rst_n=%b ready=%b cnt=%0d",
                                 cyc, rst_n_o, ready_o, lock_loss_cnt_o, e.cyc, e.rst, e.rdy, e.cnt);
                    end
                end
            end
            prev  = cur;
            first = 1'b0;
        end
    end

    initial begin
        int          n;
        logic [7:0]  cnt_exp;
        logic [7:0]  c;
        int          guard;

        reset_n_i  = 1'b0;
        pll_lock_i = 1'b0;
        sw_reset_i = 1'b0;
        push(1, 4'b0000, 1'b0, 8'd0);

        // Power-on with a lock glitch: high 5, low 1, high -> filter restarts.
        goto_cyc(3);
        reset_n_i = 1'b1;
        goto_cyc(6);
        push_seq(23, 8'd0);
        pll_lock_i = 1'b1;
        goto_cyc(11);
        pll_lock_i = 1'b0;
        goto_cyc(12);
        pll_lock_i = 1'b1;

        // One-cycle lock drop in RUN.
        goto_cyc(90);
        push(93, 4'b0000, 1'b0, 8'd1);
        push_seq(102, 8'd1);
        pll_lock_i = 1'b0;
        goto_cyc(91);
        pll_lock_i = 1'b1;

        // Single-cycle software reset in RUN: 32-cycle hold, then requalification.
        goto_cyc(170);
        push(171, 4'b0000, 1'b0, 8'd1);
        push_seq(212, 8'd1);
        sw_reset_i = 1'b1;
        goto_cyc(171);
        sw_reset_i = 1'b0;

        // Mid-RELEASE: lock loss and a 50-cycle software request hitting the FSM together.
        goto_cyc(280);
        push(283, 4'b0000, 1'b0, 8'd2);
        push(292, 4'b0001, 1'b0, 8'd2);
        push(308, 4'b0011, 1'b0, 8'd2);
        push(311, 4'b0000, 1'b0, 8'd3);
        push_seq(401, 8'd3);
        pll_lock_i = 1'b0;
        goto_cyc(281);
        pll_lock_i = 1'b1;
        goto_cyc(308);
        pll_lock_i = 1'b0;
        goto_cyc(309);
        pll_lock_i = 1'b1;
        goto_cyc(310);
        sw_reset_i = 1'b1;
        goto_cyc(360);
        sw_reset_i = 1'b0;

        // 300 lock drops from RUN: counter saturates at 255.
        n = 470;
        cnt_exp = 8'd3;
        for (int i = 0; i < 300; i++) begin
            goto_cyc(n);
            c = (cnt_exp == 8'hFF) ? 8'hFF : cnt_exp + 8'd1;
            push(n + 3, 4'b0000, 1'b0, c);
            push_seq(n + 12, c);
            pll_lock_i = 1'b0;
            goto_cyc(n + 1);
            pll_lock_i = 1'b1;
            cnt_exp = c;
            n += 80;
        end

        // Async boot reset mid-RELEASE, then a clean power-on with lock already high.
        goto_cyc(n);
        push(n + 3,  4'b0000, 1'b0, 8'd255);
        push(n + 12, 4'b0001, 1'b0, 8'd255);
        push(n + 28, 4'b0011, 1'b0, 8'd255);
        pll_lock_i = 1'b0;
        goto_cyc(n + 1);
        pll_lock_i = 1'b1;
        goto_cyc(n + 30);
        @(posedge clk);
        #3;
        push(cyc, 4'b0000, 1'b0, 8'd0);
        n = cyc;
        reset_n_i = 1'b0;
        goto_cyc(n + 2);
        push_seq(n + 13, 8'd0);
        reset_n_i = 1'b1;
        goto_cyc(n + 13 + 70);

        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_events remaining=%0d required=0 next_cyc=%0d",
                     exp_q.size(), exp_q[0].cyc);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
